// File: rtl/fifo_stream_pkg.sv
// Shared sizing for the FIFO read-side streamer and its output buffer.
package fifo_stream_pkg;

   localparam int BUF_DEPTH  = 4;
   localparam int BUF_PTR_W  = 2;
   localparam int BUF_CNT_W  = 3;
   localparam int BEAT_CNT_W = 8;

   // A read may issue only if the buffered words plus the one in flight leave a slot free.
   function automatic logic has_credit(input logic [BUF_CNT_W-1:0] count,
                                       input logic                 inflight);
      return (count + BUF_CNT_W'(inflight)) < BUF_CNT_W'(BUF_DEPTH);
   endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Small circular buffer that absorbs FIFO read latency; head word is presented combinationally.
module stream_skid_buffer
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [BUF_CNT_W-1:0]  count_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [BUF_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [BUF_CNT_W-1:0]  count_q, count_d;

   always_comb begin
      count_d = count_q;
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + BUF_CNT_W'(1);
         2'b01:   count_d = count_q - BUF_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + BUF_PTR_W'(1);
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + BUF_PTR_W'(1);
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read master: credit-gated reads, latency-compensating buffer, fixed-length packet framing.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  idle
);

   logic                  inflight_q;
   logic [BEAT_CNT_W-1:0] beat_q, beat_d;
   logic [BUF_CNT_W-1:0]  count;
   logic                  pop;

   stream_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (fifo_rd_data),
      .pop_i       (pop),
      .count_o     (count),
      .head_o      (m_data)
   );

   // Registered state only: downstream ready never reaches the FIFO strobe.
   assign fifo_rd_en = en && !fifo_empty && has_credit(count, inflight_q);

   assign m_valid = (count != '0);
   assign pop     = m_valid && m_ready;
   assign m_last  = m_valid && (beat_q == BEAT_CNT_W'(PKT_LEN - 1));
   assign idle    = (count == '0) && !inflight_q;

   always_comb begin
      beat_d = beat_q;
      if (pop) beat_d = m_last ? '0 : beat_q + BEAT_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         beat_q     <= '0;
      end else begin
         inflight_q <= fifo_rd_en;
         beat_q     <= beat_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, write-time scoreboard, per-cycle table for streaming.
module tb_fifo_stream_reader;

   localparam int DW      = 8;
   localparam int PKT_LEN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          idle;

   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int tb_beat = 0;
   logic rd_s = 1'b0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] pop_dat[$];
   int            pop_cyc[$];

   typedef struct {
      logic          en;
      logic          rdy;
      logic          exp_rd;
      logic          exp_v;
      logic [DW-1:0] exp_d;
      logic          exp_l;
   } vec_t;
   vec_t tbl[11];

   fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .idle         (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Observe at the falling edge; score any handshake against the write-order queue.
   task automatic sample();
      logic [DW-1:0] e;
      @(negedge clk);
      cyc++;
      rd_s = fifo_rd_en;
      if (fifo_rd_en) rd_cnt++;
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_pop actual=%0h expected=none", m_data);
         end else begin
            e = exp_q.pop_front();
            chk("pop_data", 32'(m_data), 32'(e));
            chk("pop_last", 32'(m_last), 32'(tb_beat == PKT_LEN - 1));
            tb_beat = (tb_beat == PKT_LEN - 1) ? 0 : tb_beat + 1;
            pop_dat.push_back(m_data);
            pop_cyc.push_back(cyc);
         end
      end
   endtask

   // FIFO model: read data appears just after the edge that accepted the read.
   task automatic advance();
      @(posedge clk);
      #1;
      if (rd_s) begin
         checks++;
         if (fq.size() == 0) begin
            failures++;
            $display("FAIL fifo_over_read actual=read expected=no_read");
         end else begin
            fifo_rd_data = fq.pop_front();
         end
      end
      if (wr_en) begin
         fq.push_back(wr_data);
         exp_q.push_back(wr_data);
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic fifo_write(input logic [DW-1:0] d);
      wr_en = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic drain(input string name, input int maxc);
      bit done;
      done = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < maxc && !done; i++) begin
         if (exp_q.size() == 0 && idle) done = 1'b1;
         else tick();
      end
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      m_ready = 1'b0;
      tick();
      tick();
      fq.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      tb_beat = 0;
      sample();
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_last", 32'(m_last), 32'd0);
      advance();
      rst = 1'b0;
   endtask

   initial begin
      // Streaming: cycle 0 is the first cycle with en high after an 8-word preload.
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

      // Reset held while the FIFO already holds three words.
      m_ready = 1'b1;
      fifo_write(8'hA1);
      fifo_write(8'hA2);
      fifo_write(8'hA3);
      sample();
      chk("hold_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("hold_valid", 32'(m_valid), 32'd0);
      chk("hold_idle", 32'(idle), 32'd1);
      chk("hold_data", 32'(m_data), 32'd0);
      advance();
      rst = 1'b0;
      en = 1'b1;
      sample();
      chk("release_rd_en", 32'(fifo_rd_en), 32'd1);
      advance();
      drain("release", 30);

      // Full-rate streaming, compared cycle by cycle.
      do_reset();
      for (int i = 1; i <= 8; i++) fifo_write(8'(i));
      rd_cnt = 0;
      for (int i = 0; i < 11; i++) begin
         en = tbl[i].en;
         m_ready = tbl[i].rdy;
         sample();
         chk($sformatf("stream_rd_en[%0d]", i), 32'(fifo_rd_en), 32'(tbl[i].exp_rd));
         chk($sformatf("stream_valid[%0d]", i), 32'(m_valid), 32'(tbl[i].exp_v));
         if (tbl[i].exp_v) chk($sformatf("stream_data[%0d]", i), 32'(m_data), 32'(tbl[i].exp_d));
         chk($sformatf("stream_last[%0d]", i), 32'(m_last), 32'(tbl[i].exp_l));
         advance();
      end
      chk("stream_reads", 32'(rd_cnt), 32'd8);
      chk("stream_left", 32'(exp_q.size()), 32'd0);

      // Backpressure: at most four words are pulled, head word frozen.
      do_reset();
      for (int i = 0; i < 8; i++) fifo_write(8'h10 + 8'(i));
      rd_cnt = 0;
      m_ready = 1'b0;
      en = 1'b1;
      repeat (20) tick();
      chk("bp_reads", 32'(rd_cnt), 32'd4);
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_data", 32'(m_data), 32'h10);
      chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("bp_fifo_left", 32'(fq.size()), 32'd4);
      pop_dat.delete();
      drain("bp", 40);
      chk("bp_pops", 32'(pop_dat.size()), 32'd8);

      // FIFO runs dry mid-packet.
      pop_dat.delete();
      pop_cyc.delete();
      en = 1'b1;
      m_ready = 1'b1;
      fifo_write(8'h21);
      fifo_write(8'h22);
      repeat (10) tick();
      fifo_write(8'h23);
      fifo_write(8'h24);
      drain("uf", 30);
      chk("uf_pops", 32'(pop_dat.size()), 32'd4);
      if (pop_cyc.size() == 4) chk("uf_gap", 32'(pop_cyc[2] - pop_cyc[1] > 1), 32'd1);

      // en dropped right after one accepted read.
      pop_dat.delete();
      en = 1'b0;
      fifo_write(8'h31);
      fifo_write(8'h32);
      fifo_write(8'h33);
      rd_cnt = 0;
      en = 1'b1;
      tick();
      en = 1'b0;
      repeat (6) tick();
      chk("en_reads", 32'(rd_cnt), 32'd1);
      chk("en_pops", 32'(pop_dat.size()), 32'd1);
      chk("en_pending", 32'(exp_q.size()), 32'd2);
      en = 1'b1;
      drain("en", 30);

      // Reset after two beats of a packet; framing restarts at beat 0.
      do_reset();
      for (int i = 0; i < 8; i++) fifo_write(8'h41 + 8'(i));
      pop_dat.delete();
      en = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 20 && pop_dat.size() < 2; i++) tick();
      chk("mid_pops", 32'(pop_dat.size()), 32'd2);
      do_reset();
      pop_dat.delete();
      for (int i = 0; i < 4; i++) fifo_write(8'h51 + 8'(i));
      en = 1'b1;
      drain("mid", 30);
      chk("mid_after_pops", 32'(pop_dat.size()), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
